// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared types and constants for the 8-bit core instruction fetch.
//          fetch_state_t  - fetch sequencer states
//          PC_W_DFLT      - default PC / imem address width
//          INSTR_W_DFLT   - default instruction word width
//          BR_FWD/BR_BACK - branch direction encodings for br_back_i
// Rev    : 1.0  initial release
// ============================================================================
package fetch_pkg;

   localparam int PC_W_DFLT    = 8;
   localparam int INSTR_W_DFLT = 9;

   localparam logic BR_FWD  = 1'b0;
   localparam logic BR_BACK = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } fetch_state_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_target_calc.sv
`default_nettype none
// ============================================================================
// Module : fetch_target_calc
// Brief  : Combinational relative-branch target. The offset is a magnitude
//          applied to the address following the branch (br_pc_i + 1), added
//          for forward and subtracted for backward branches; all arithmetic
//          wraps modulo 2**PC_W.
// Ports  : br_pc_i     in  PC of the branch instruction
//          br_back_i   in  direction (BR_FWD / BR_BACK)
//          br_target_i in  unsigned offset magnitude
//          target_o    out redirect address
// Rev    : 1.0  initial release
// ============================================================================
module fetch_target_calc #(
   parameter int PC_W = fetch_pkg::PC_W_DFLT
) (
   input  logic [PC_W-1:0] br_pc_i,
   input  logic            br_back_i,
   input  logic [PC_W-1:0] br_target_i,
   output logic [PC_W-1:0] target_o
);
   import fetch_pkg::*;

   localparam logic [PC_W-1:0] c_pc_one = {{(PC_W-1){1'b0}}, 1'b1};

   logic [PC_W-1:0] w_base;

   assign w_base   = br_pc_i + c_pc_one;
   assign target_o = (br_back_i == BR_BACK) ? (w_base - br_target_i)
                                            : (w_base + br_target_i);

endmodule : fetch_target_calc
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : fetch_unit
// Brief  : Architectural PC and instruction-fetch sequencer. Issues
//          held-until-ack reads to instruction memory, buffers one
//          instruction toward decode, and applies start loads and relative
//          branch redirects, squashing any fetch already in flight.
// Ports  : clk_i, reset_i (async, active high)
//          start_i/startadd_i          load PC and begin fetching
//          halt_i                      stop issuing fetches
//          br_valid_i/br_back_i/br_target_i/br_pc_i   branch redirect
//          imem_req_o/imem_addr_o/imem_ack_i/imem_data_i  imem read port
//          instr_valid_o/instr_o/instr_pc_o/instr_ready_i decode handshake
//          running_o                   high in FETCH or DRAIN
// Config : FETCH_PERF_CNT_EN adds fetch_cnt_o / squash_cnt_o (saturating,
//          cleared by reset only).
// Rev    : 1.0  initial release
// ============================================================================
module fetch_unit #(
   parameter int PC_W    = fetch_pkg::PC_W_DFLT,
   parameter int INSTR_W = fetch_pkg::INSTR_W_DFLT
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               start_i,
   input  logic [PC_W-1:0]    startadd_i,
   input  logic               halt_i,
   input  logic               br_valid_i,
   input  logic               br_back_i,
   input  logic [PC_W-1:0]    br_target_i,
   input  logic [PC_W-1:0]    br_pc_i,
   output logic               imem_req_o,
   output logic [PC_W-1:0]    imem_addr_o,
   input  logic               imem_ack_i,
   input  logic [INSTR_W-1:0] imem_data_i,
   output logic               instr_valid_o,
   output logic [INSTR_W-1:0] instr_o,
   output logic [PC_W-1:0]    instr_pc_o,
   input  logic               instr_ready_i,
`ifdef FETCH_PERF_CNT_EN
   output logic [15:0]        fetch_cnt_o,
   output logic [15:0]        squash_cnt_o,
`endif
   output logic               running_o
);
   import fetch_pkg::*;

   localparam logic [PC_W-1:0] c_pc_one = {{(PC_W-1){1'b0}}, 1'b1};

   fetch_state_t        state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic                halt_pend_q, halt_pend_d;
   logic                req_q;
   logic [PC_W-1:0]     addr_q;
   logic                buf_valid_q;
   logic [INSTR_W-1:0]  buf_instr_q;
   logic [PC_W-1:0]     buf_pc_q;

   logic                w_new_req;
   logic                w_req;
   logic [PC_W-1:0]     w_addr;
   logic                w_deq;
   logic                w_flush;
   logic                w_wr_buf;
   logic [PC_W-1:0]     w_br_target;

   fetch_target_calc #(
      .PC_W (PC_W)
   ) u_target (
      .br_pc_i     (br_pc_i),
      .br_back_i   (br_back_i),
      .br_target_i (br_target_i),
      .target_o    (w_br_target)
   );

   // A new read may start only in a quiet FETCH cycle with room in the
   // buffer (empty, or being emptied this cycle). Once started, req_q holds
   // the request and address until ack regardless of any other input.
   assign w_new_req = (state_q == FETCH) && !req_q && !start_i && !br_valid_i &&
                      !halt_i && !halt_pend_q && (!buf_valid_q || instr_ready_i);
   assign w_req     = req_q || w_new_req;
   // While a request is outstanding in FETCH, addr_q equals pc_q; in DRAIN
   // pc_q already holds the redirect target while addr_q keeps the old one.
   assign w_addr    = req_q ? addr_q : pc_q;
   assign w_deq     = buf_valid_q && instr_ready_i;

   assign imem_req_o    = w_req;
   assign imem_addr_o   = w_addr;
   assign instr_valid_o = buf_valid_q;
   assign instr_o       = buf_instr_q;
   assign instr_pc_o    = buf_pc_q;
   assign running_o     = (state_q == FETCH) || (state_q == DRAIN);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      halt_pend_d = halt_pend_q;
      w_flush     = 1'b0;
      w_wr_buf    = 1'b0;
      case (state_q)
         IDLE, HALTED: begin
            if (start_i) begin
               pc_d        = startadd_i;
               w_flush     = 1'b1;
               halt_pend_d = 1'b0;
               state_d     = FETCH;
            end
         end
         FETCH: begin
            if (start_i || br_valid_i) begin
               pc_d    = start_i ? startadd_i : w_br_target;
               w_flush = 1'b1;
               if (start_i) begin
                  halt_pend_d = 1'b0;
               end
               // An ack landing this cycle belongs to the old stream and is
               // simply dropped; an unanswered request must still be drained.
               if (req_q && !imem_ack_i) begin
                  state_d = DRAIN;
               end
            end else begin
               if (w_req && imem_ack_i) begin
                  w_wr_buf = 1'b1;
                  pc_d     = w_addr + c_pc_one;
               end
               if (halt_i || halt_pend_q) begin
                  if (req_q && !imem_ack_i) begin
                     halt_pend_d = 1'b1;
                  end else begin
                     halt_pend_d = 1'b0;
                     state_d     = HALTED;
                  end
               end
            end
         end
         DRAIN: begin
            if (start_i) begin
               pc_d        = startadd_i;
               w_flush     = 1'b1;
               halt_pend_d = 1'b0;
            end else if (br_valid_i) begin
               pc_d    = w_br_target;
               w_flush = 1'b1;
            end else if (halt_i) begin
               halt_pend_d = 1'b1;
            end
            if (imem_ack_i) begin
               state_d     = halt_pend_d ? HALTED : FETCH;
               halt_pend_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         pc_q        <= '0;
         halt_pend_q <= 1'b0;
         req_q       <= 1'b0;
         addr_q      <= '0;
         buf_valid_q <= 1'b0;
         buf_instr_q <= '0;
         buf_pc_q    <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         halt_pend_q <= halt_pend_d;
         req_q       <= w_req && !imem_ack_i;
         addr_q      <= w_addr;
         // A flush overrides both a write and a same-cycle hand-off.
         if (w_flush) begin
            buf_valid_q <= 1'b0;
         end else if (w_wr_buf) begin
            buf_valid_q <= 1'b1;
            buf_instr_q <= imem_data_i;
            buf_pc_q    <= w_addr;
         end else if (w_deq) begin
            buf_valid_q <= 1'b0;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_cnt_q;
   logic [15:0] squash_cnt_q;
   logic        w_squash_ack;
   logic        w_squash_buf;
   logic [1:0]  w_squash_inc;
   logic [16:0] w_squash_sum;

   // Acked reads whose data is thrown away: every ack in DRAIN, and an ack
   // that coincides with a start/redirect in FETCH.
   assign w_squash_ack = imem_ack_i && req_q &&
                         ((state_q == DRAIN) ||
                          ((state_q == FETCH) && (start_i || br_valid_i)));
   assign w_squash_buf = w_flush && buf_valid_q;
   assign w_squash_inc = {1'b0, w_squash_ack} + {1'b0, w_squash_buf};
   assign w_squash_sum = {1'b0, squash_cnt_q} + {15'd0, w_squash_inc};

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         fetch_cnt_q  <= '0;
         squash_cnt_q <= '0;
      end else begin
         if (w_wr_buf && (fetch_cnt_q != 16'hFFFF)) begin
            fetch_cnt_q <= fetch_cnt_q + 16'd1;
         end
         squash_cnt_q <= w_squash_sum[16] ? 16'hFFFF : w_squash_sum[15:0];
      end
   end

   assign fetch_cnt_o  = fetch_cnt_q;
   assign squash_cnt_o = squash_cnt_q;
`endif

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_unit
// Brief  : Self-checking bench for fetch_unit. A per-cycle vector table
//          covers start, full-rate fetch, PC wrap, forward/backward
//          redirects and halt with a stalled decode; hand-written sequences
//          cover redirect during an outstanding read and async reset.
//          The imem model acks after a programmable number of wait cycles
//          and returns {1, addr ^ 5A}.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

   logic       clk_i;
   logic       reset_i;
   logic       start_i;
   logic [7:0] startadd_i;
   logic       halt_i;
   logic       br_valid_i;
   logic       br_back_i;
   logic [7:0] br_target_i;
   logic [7:0] br_pc_i;
   logic       imem_req_o;
   logic [7:0] imem_addr_o;
   logic       imem_ack_i;
   logic [8:0] imem_data_i;
   logic       instr_valid_o;
   logic [8:0] instr_o;
   logic [7:0] instr_pc_o;
   logic       instr_ready_i;
   logic       running_o;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_cnt_o;
   logic [15:0] squash_cnt_o;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int delay    = 0;
   int wait_cnt;

   fetch_unit dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .start_i       (start_i),
      .startadd_i    (startadd_i),
      .halt_i        (halt_i),
      .br_valid_i    (br_valid_i),
      .br_back_i     (br_back_i),
      .br_target_i   (br_target_i),
      .br_pc_i       (br_pc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_ack_i    (imem_ack_i),
      .imem_data_i   (imem_data_i),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o),
      .instr_ready_i (instr_ready_i),
`ifdef FETCH_PERF_CNT_EN
      .fetch_cnt_o   (fetch_cnt_o),
      .squash_cnt_o  (squash_cnt_o),
`endif
      .running_o     (running_o)
   );

   function automatic logic [8:0] mem_word(input logic [7:0] a);
      return {1'b1, a ^ 8'h5A};
   endfunction

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // imem model: ack once the request has waited 'delay' cycles.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)                        wait_cnt <= 0;
      else if (imem_req_o && !imem_ack_i) wait_cnt <= wait_cnt + 1;
      else                                wait_cnt <= 0;
   end
   assign imem_ack_i  = imem_req_o && (wait_cnt >= delay);
   assign imem_data_i = mem_word(imem_addr_o);

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (time %0t, required end before 200000)", $time);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #2;
   endtask

   task automatic idle_inputs();
      start_i    = 1'b0;
      halt_i     = 1'b0;
      br_valid_i = 1'b0;
   endtask

   typedef struct {
      logic       start;
      logic [7:0] sa;
      logic       halt;
      logic       br;
      logic       back;
      logic [7:0] tgt;
      logic [7:0] bpc;
      logic       rdy;
      logic       e_req;
      logic [7:0] e_addr;
      logic       e_valid;
      logic [7:0] e_pc;
      logic       e_run;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   function automatic vec_t v(input logic st, input logic [7:0] sa, input logic h,
                              input logic br, input logic bk, input logic [7:0] tg,
                              input logic [7:0] bp, input logic rd, input logic er,
                              input logic [7:0] ea, input logic ev, input logic [7:0] ep,
                              input logic eru);
      vec_t r;
      r.start = st; r.sa = sa; r.halt = h; r.br = br; r.back = bk; r.tgt = tg;
      r.bpc = bp; r.rdy = rd; r.e_req = er; r.e_addr = ea; r.e_valid = ev;
      r.e_pc = ep; r.e_run = eru;
      return r;
   endfunction

   initial begin
      //           st sa     h  br bk tgt    bpc    rdy req addr   vld pc     run
      vecs[0]  = v(1, 8'h10, 0, 0, 0, 8'h00, 8'h00, 1,  0, 8'h00, 0, 8'h00, 0);
      vecs[1]  = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1,  1, 8'h10, 0, 8'h00, 1);
      vecs[2]  = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1,  1, 8'h11, 1, 8'h10, 1);
      vecs[3]  = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1,  1, 8'h12, 1, 8'h11, 1);
      vecs[4]  = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1,  1, 8'h13, 1, 8'h12, 1);
      vecs[5]  = v(1, 8'hFE, 0, 0, 0, 8'h00, 8'h00, 1,  0, 8'h14, 1, 8'h13, 1);
      vecs[6]  = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1,  1, 8'hFE, 0, 8'h00, 1);
      vecs[7]  = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1,  1, 8'hFF, 1, 8'hFE, 1);
      vecs[8]  = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1,  1, 8'h00, 1, 8'hFF, 1);
      vecs[9]  = v(0, 8'h00, 0, 1, 0, 8'h05, 8'h20, 1,  0, 8'h01, 1, 8'h00, 1);
      vecs[10] = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1,  1, 8'h26, 0, 8'h00, 1);
      vecs[11] = v(0, 8'h00, 0, 1, 1, 8'h03, 8'h20, 1,  0, 8'h27, 1, 8'h26, 1);
      vecs[12] = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1,  1, 8'h1E, 0, 8'h00, 1);
      vecs[13] = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0,  0, 8'h1F, 1, 8'h1E, 1);
      vecs[14] = v(0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0,  0, 8'h1F, 1, 8'h1E, 1);
      vecs[15] = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0,  0, 8'h1F, 1, 8'h1E, 0);
      vecs[16] = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1,  0, 8'h1F, 1, 8'h1E, 0);
      vecs[17] = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1,  0, 8'h1F, 0, 8'h00, 0);
      vecs[18] = v(1, 8'h40, 0, 0, 0, 8'h00, 8'h00, 1,  0, 8'h1F, 0, 8'h00, 0);
      vecs[19] = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1,  1, 8'h40, 0, 8'h00, 1);
      vecs[20] = v(0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1,  1, 8'h41, 1, 8'h40, 1);

      reset_i       = 1'b1;
      startadd_i    = 8'h00;
      br_back_i     = 1'b0;
      br_target_i   = 8'h00;
      br_pc_i       = 8'h00;
      instr_ready_i = 1'b1;
      delay         = 0;
      idle_inputs();

      // ---------------- reset state ----------------
      repeat (3) step();
      #1;
      chk("reset req",     {31'd0, imem_req_o},    32'd0);
      chk("reset addr",    {24'd0, imem_addr_o},   32'd0);
      chk("reset valid",   {31'd0, instr_valid_o}, 32'd0);
      chk("reset instr",   {23'd0, instr_o},       32'd0);
      chk("reset pc",      {24'd0, instr_pc_o},    32'd0);
      chk("reset running", {31'd0, running_o},     32'd0);
      reset_i = 1'b0;

      // ---------------- vector table ----------------
      for (int i = 0; i < NV; i++) begin
         step();
         start_i       = vecs[i].start;
         startadd_i    = vecs[i].sa;
         halt_i        = vecs[i].halt;
         br_valid_i    = vecs[i].br;
         br_back_i     = vecs[i].back;
         br_target_i   = vecs[i].tgt;
         br_pc_i       = vecs[i].bpc;
         instr_ready_i = vecs[i].rdy;
         #1;
         chk($sformatf("row%0d req", i),   {31'd0, imem_req_o},    {31'd0, vecs[i].e_req});
         chk($sformatf("row%0d addr", i),  {24'd0, imem_addr_o},   {24'd0, vecs[i].e_addr});
         chk($sformatf("row%0d valid", i), {31'd0, instr_valid_o}, {31'd0, vecs[i].e_valid});
         chk($sformatf("row%0d run", i),   {31'd0, running_o},     {31'd0, vecs[i].e_run});
         if (vecs[i].e_valid) begin
            chk($sformatf("row%0d ipc", i),   {24'd0, instr_pc_o}, {24'd0, vecs[i].e_pc});
            chk($sformatf("row%0d instr", i), {23'd0, instr_o},    {23'd0, mem_word(vecs[i].e_pc)});
         end
      end

      // ---------------- redirect during outstanding read ----------------
      step();                       // b0: restart at 0x50, reads now wait 3 cycles
      idle_inputs();
      instr_ready_i = 1'b1;
      start_i       = 1'b1;
      startadd_i    = 8'h50;
      delay         = 3;
      step();                       // b1: read of 0x50 issued, not acked
      idle_inputs();
      #1;
      chk("drain b1 req",  {31'd0, imem_req_o}, 32'd1);
      chk("drain b1 addr", {24'd0, imem_addr_o}, 32'h50);
      step();                       // b2: forward redirect 0x60+1+0 = 0x61
      br_valid_i  = 1'b1;
      br_back_i   = 1'b0;
      br_pc_i     = 8'h60;
      br_target_i = 8'h00;
      #1;
      chk("drain b2 addr", {24'd0, imem_addr_o}, 32'h50);
      step();                       // b3: DRAIN, old request still held
      idle_inputs();
      #1;
      chk("drain b3 req",  {31'd0, imem_req_o}, 32'd1);
      chk("drain b3 addr", {24'd0, imem_addr_o}, 32'h50);
      chk("drain b3 run",  {31'd0, running_o},  32'd1);
      step();                       // b4: stale ack arrives and is discarded
      #1;
      chk("drain b4 ack",  {31'd0, imem_ack_i}, 32'd1);
      step();                       // b5: fresh read at the target
      delay = 0;
      #1;
      chk("drain b5 addr",  {24'd0, imem_addr_o},   32'h61);
      chk("drain b5 valid", {31'd0, instr_valid_o}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
      chk("perf fetch_cnt",  {16'd0, fetch_cnt_o},  32'd11);
      chk("perf squash_cnt", {16'd0, squash_cnt_o}, 32'd5);
`endif
      step();                       // b6: target instruction delivered
      delay = 3;
      #1;
      chk("drain b6 valid", {31'd0, instr_valid_o}, 32'd1);
      chk("drain b6 ipc",   {24'd0, instr_pc_o},    32'h61);
      chk("drain b6 instr", {23'd0, instr_o},       {23'd0, mem_word(8'h61)});
      chk("drain b6 addr",  {24'd0, imem_addr_o},   32'h62);

      // ---------------- asynchronous reset mid-request ----------------
      step();
      #1;
      chk("rst pre req", {31'd0, imem_req_o}, 32'd1);
      reset_i = 1'b1;
      #1;
      chk("rst req",   {31'd0, imem_req_o},    32'd0);
      chk("rst valid", {31'd0, instr_valid_o}, 32'd0);
      chk("rst run",   {31'd0, running_o},     32'd0);
      chk("rst addr",  {24'd0, imem_addr_o},   32'd0);
`ifdef FETCH_PERF_CNT_EN
      chk("rst fetch_cnt",  {16'd0, fetch_cnt_o},  32'd0);
      chk("rst squash_cnt", {16'd0, squash_cnt_o}, 32'd0);
`endif
      step();
      reset_i = 1'b0;
      step();
      #1;
      chk("post rst req", {31'd0, imem_req_o}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_fetch_unit
`default_nettype wire
